// File: rtl/rom_boot_loader.sv
// ----------------------------------------------------------------------------
// rom_boot_loader
//
// Program-load controller for the instruction ROM. A byte stream arriving on a
// valid/ready interface is packed little-endian into 32-bit words, and each
// completed word (or the trailing partial word) is written to the ROM with a
// single-cycle strobe. The core is held in reset until the whole image has
// been written.
//
// Ports
//   clk            clock, all logic on the rising edge
//   rst_n          synchronous reset, active low
//   start_i        begin a load (honoured in IDLE/DONE/ERR only)
//   len_i          image length in bytes, sampled together with start_i
//   byte_valid_i   source byte valid
//   byte_i         source byte
//   byte_ready_o   loader accepts a byte this cycle (RECV only)
//   rom_we_o       ROM word write strobe, one cycle wide
//   rom_waddr_o    ROM word index of the strobed word
//   rom_wdata_o    ROM word data of the strobed word
//   core_rst_o     active-high reset to the core, low only in DONE
//   busy_o         loader is receiving (RECV)
//   done_o         image complete (DONE, level)
//   err_o          load aborted or rejected (ERR, level)
// ----------------------------------------------------------------------------
module rom_boot_loader #(
  parameter int ROM_ADDR_WIDTH = 16,
  parameter int IDLE_TIMEOUT   = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [ROM_ADDR_WIDTH:0]   len_i,
  input  logic                      byte_valid_i,
  input  logic [7:0]                byte_i,
  output logic                      byte_ready_o,
  output logic                      rom_we_o,
  output logic [ROM_ADDR_WIDTH-3:0] rom_waddr_o,
  output logic [31:0]               rom_wdata_o,
  output logic                      core_rst_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
);

  localparam int TO_W = $clog2(IDLE_TIMEOUT + 1);

  // Largest legal image: the whole ROM, 2**ROM_ADDR_WIDTH bytes.
  localparam logic [ROM_ADDR_WIDTH:0] MAX_LEN = {1'b1, {ROM_ADDR_WIDTH{1'b0}}};
  localparam logic [ROM_ADDR_WIDTH:0] CNT_ONE = (ROM_ADDR_WIDTH + 1)'(1);
  localparam logic [TO_W-1:0]         TO_ONE  = TO_W'(1);
  // Abort fires on the idle cycle that would bring the count to IDLE_TIMEOUT.
  localparam logic [TO_W-1:0]         TO_LAST = TO_W'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [ROM_ADDR_WIDTH:0]   len_q, len_d;
  logic [ROM_ADDR_WIDTH:0]   byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0]           to_cnt_q, to_cnt_d;
  logic [31:0]               pack_q, pack_d;
  logic                      we_q, we_d;
  logic [ROM_ADDR_WIDTH-3:0] waddr_q, waddr_d;
  logic [31:0]               wdata_q, wdata_d;

  logic                      in_recv;
  logic                      hs;
  logic [1:0]                lane;
  logic [ROM_ADDR_WIDTH:0]   cnt_inc;
  logic                      last_byte;
  logic                      flush;
  logic                      len_bad;
  logic                      timed_out;
  logic [31:0]               word_ins;

  // Place byte b into lane ln of word w (lane 0 = bits 7:0).
  function automatic logic [31:0] ins_byte(input logic [31:0] w,
                                           input logic [1:0]  ln,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = w;
    case (ln)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  assign in_recv   = (state_q == S_RECV);
  assign hs        = in_recv && byte_valid_i;
  assign lane      = byte_cnt_q[1:0];
  assign cnt_inc   = byte_cnt_q + CNT_ONE;
  assign last_byte = (cnt_inc == len_q);
  assign flush     = hs && ((lane == 2'd3) || last_byte);
  assign len_bad   = (len_i == '0) || (len_i > MAX_LEN);
  assign timed_out = in_recv && !hs && (to_cnt_q == TO_LAST);
  assign word_ins  = ins_byte(pack_q, lane, byte_i);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RECV: begin
        if (hs && last_byte) begin
          state_d = S_DONE;
        end else if (timed_out) begin
          state_d = S_ERR;
        end
      end
      default: begin
        if (start_i) begin
          state_d = len_bad ? S_ERR : S_RECV;
        end
      end
    endcase
  end

  // Output decode; every source is a register, so outputs stay glitch-free.
  always_comb begin
    byte_ready_o = in_recv;
    busy_o       = in_recv;
    done_o       = (state_q == S_DONE);
    err_o        = (state_q == S_ERR);
    core_rst_o   = (state_q != S_DONE);
    rom_we_o     = we_q;
    rom_waddr_o  = waddr_q;
    rom_wdata_o  = wdata_q;
  end

  // Datapath next-state: counters, packing register and write port
  always_comb begin
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    to_cnt_d   = to_cnt_q;
    pack_d     = pack_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;

    if (in_recv) begin
      if (hs) begin
        byte_cnt_d = cnt_inc;
        to_cnt_d   = '0;
        if (flush) begin
          we_d    = 1'b1;
          waddr_d = byte_cnt_q[ROM_ADDR_WIDTH-1:2];
          wdata_d = word_ins;
          pack_d  = '0;
        end else begin
          pack_d  = word_ins;
        end
      end else begin
        to_cnt_d = to_cnt_q + TO_ONE;
        // Abort drops any partially packed word without writing it.
        if (timed_out) begin
          pack_d = '0;
        end
      end
    end else if (start_i && !len_bad) begin
      len_d      = len_i;
      byte_cnt_d = '0;
      to_cnt_d   = '0;
      pack_d     = '0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q      <= '0;
      byte_cnt_q <= '0;
      to_cnt_q   <= '0;
      pack_q     <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      to_cnt_q   <= to_cnt_d;
      pack_q     <= pack_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_rom_boot_loader.sv
module tb_rom_boot_loader;

  localparam int AW = 6;   // 64-byte ROM, 16 words
  localparam int TO = 8;

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic [AW:0]   len_i;
  logic          byte_valid_i;
  logic [7:0]    byte_i;
  logic          byte_ready_o;
  logic          rom_we_o;
  logic [AW-3:0] rom_waddr_o;
  logic [31:0]   rom_wdata_o;
  logic          core_rst_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [31:0] mon_addr[$];
  logic [31:0] mon_data[$];

  rom_boot_loader #(
    .ROM_ADDR_WIDTH(AW),
    .IDLE_TIMEOUT  (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .len_i       (len_i),
    .byte_valid_i(byte_valid_i),
    .byte_i      (byte_i),
    .byte_ready_o(byte_ready_o),
    .rom_we_o    (rom_we_o),
    .rom_waddr_o (rom_waddr_o),
    .rom_wdata_o (rom_wdata_o),
    .core_rst_o  (core_rst_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe is one full cycle wide, so each write is seen once at the falling edge.
  always @(negedge clk) begin
    if (rom_we_o === 1'b1) begin
      mon_addr.push_back(32'(rom_waddr_o));
      mon_data.push_back(rom_wdata_o);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mon_a(input int k);
    return (mon_addr.size() > k) ? mon_addr[k] : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] mon_d(input int k);
    return (mon_data.size() > k) ? mon_data[k] : 32'hxxxxxxxx;
  endfunction

  task automatic start_load(input logic [AW:0] len);
    start_i = 1'b1;
    len_i   = len;
    step();
    start_i = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid_i = 1'b1;
    byte_i       = b;
    step();
  endtask

  initial begin
    rst_n        = 1'b0;
    start_i      = 1'b0;
    len_i        = '0;
    byte_valid_i = 1'b0;
    byte_i       = '0;
    repeat (3) step();

    // Reset state
    chk("rst_we",    32'(rom_we_o),     32'd0);
    chk("rst_waddr", 32'(rom_waddr_o),  32'd0);
    chk("rst_wdata", rom_wdata_o,       32'd0);
    chk("rst_ready", 32'(byte_ready_o), 32'd0);
    chk("rst_busy",  32'(busy_o),       32'd0);
    chk("rst_done",  32'(done_o),       32'd0);
    chk("rst_err",   32'(err_o),        32'd0);
    chk("rst_core",  32'(core_rst_o),   32'd1);
    rst_n = 1'b1;
    step();

    // 1: len 8, two words back-to-back
    mon_addr.delete(); mon_data.delete();
    start_load(8);
    chk("t1_busy",  32'(busy_o),       32'd1);
    chk("t1_ready", 32'(byte_ready_o), 32'd1);
    chk("t1_core",  32'(core_rst_o),   32'd1);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    chk("t1_we0",    32'(rom_we_o),    32'd1);
    chk("t1_wdata0", rom_wdata_o,      32'h0000_0013);
    send(8'h6F); chk("t1_we_gap", 32'(rom_we_o), 32'd0);
    send(8'h00); send(8'h00); send(8'h00);
    chk("t1_we1",    32'(rom_we_o),    32'd1);
    chk("t1_waddr1", 32'(rom_waddr_o), 32'd1);
    chk("t1_wdata1", rom_wdata_o,      32'h0000_006F);
    chk("t1_done",   32'(done_o),      32'd1);
    chk("t1_core0",  32'(core_rst_o),  32'd0);
    byte_valid_i = 1'b0;
    step();
    chk("t1_we_off", 32'(rom_we_o), 32'd0);
    chk("t1_nwr",    32'(mon_data.size()), 32'd2);
    chk("t1_a0",     mon_a(0), 32'd0);
    chk("t1_d0",     mon_d(0), 32'h0000_0013);
    chk("t1_a1",     mon_a(1), 32'd1);
    chk("t1_d1",     mon_d(1), 32'h0000_006F);

    // 2: len 6, partial final word zero-filled
    mon_addr.delete(); mon_data.delete();
    start_load(6);
    chk("t2_core", 32'(core_rst_o), 32'd1);
    chk("t2_done", 32'(done_o),     32'd0);
    for (int i = 1; i <= 6; i++) send(8'(i));
    chk("t2_done2", 32'(done_o), 32'd1);
    byte_valid_i = 1'b0;
    step();
    chk("t2_nwr", 32'(mon_data.size()), 32'd2);
    chk("t2_a0",  mon_a(0), 32'd0);
    chk("t2_d0",  mon_d(0), 32'h0403_0201);
    chk("t2_a1",  mon_a(1), 32'd1);
    chk("t2_d1",  mon_d(1), 32'h0000_0605);

    // 3: gaps of 3 idle cycles stay under the timeout
    mon_addr.delete(); mon_data.delete();
    start_load(4);
    send(8'h11); byte_valid_i = 1'b0; repeat (3) step();
    send(8'h22); byte_valid_i = 1'b0; repeat (3) step();
    send(8'h33); byte_valid_i = 1'b0; repeat (3) step();
    chk("t3_err_mid", 32'(err_o), 32'd0);
    send(8'h44); byte_valid_i = 1'b0;
    chk("t3_done", 32'(done_o), 32'd1);
    step();
    chk("t3_err",  32'(err_o), 32'd0);
    chk("t3_nwr",  32'(mon_data.size()), 32'd1);
    chk("t3_d0",   mon_d(0), 32'h4433_2211);

    // 4: stall after 5 bytes -> abort, then recover
    mon_addr.delete(); mon_data.delete();
    start_load(8);
    for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i));
    byte_valid_i = 1'b0;
    repeat (TO - 1) step();
    chk("t4_err_early", 32'(err_o), 32'd0);
    chk("t4_busy",      32'(busy_o), 32'd1);
    step();
    chk("t4_err",   32'(err_o),        32'd1);
    chk("t4_core",  32'(core_rst_o),   32'd1);
    chk("t4_ready", 32'(byte_ready_o), 32'd0);
    step();
    chk("t4_nwr",   32'(mon_data.size()), 32'd1);
    chk("t4_d0",    mon_d(0), 32'hA3A2_A1A0);
    mon_addr.delete(); mon_data.delete();
    start_load(4);
    chk("t4_err_clr", 32'(err_o), 32'd0);
    send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
    byte_valid_i = 1'b0;
    chk("t4_rdone", 32'(done_o), 32'd1);
    step();
    chk("t4_rnwr",  32'(mon_data.size()), 32'd1);
    chk("t4_ra0",   mon_a(0), 32'd0);
    chk("t4_rd0",   mon_d(0), 32'hD4C3_B2A1);

    // 5: illegal lengths and a full-ROM image
    start_load(0);
    chk("t5_len0", 32'(err_o), 32'd1);
    start_load(7'd65);
    chk("t5_lenbig_err",  32'(err_o),  32'd1);
    chk("t5_lenbig_busy", 32'(busy_o), 32'd0);
    mon_addr.delete(); mon_data.delete();
    start_load(7'd64);
    chk("t5_full_busy", 32'(busy_o), 32'd1);
    for (int i = 0; i < 64; i++) begin
      // A start with a bad length while receiving must be ignored.
      start_i = (i == 10);
      len_i   = '0;
      send(8'(i));
    end
    start_i      = 1'b0;
    byte_valid_i = 1'b0;
    chk("t5_last_we",    32'(rom_we_o),    32'd1);
    chk("t5_last_waddr", 32'(rom_waddr_o), 32'd15);
    chk("t5_last_wdata", rom_wdata_o,      32'h3F3E_3D3C);
    chk("t5_full_done",  32'(done_o),      32'd1);
    chk("t5_full_err",   32'(err_o),       32'd0);
    step();
    chk("t5_nwr", 32'(mon_data.size()), 32'd16);
    chk("t5_a0",  mon_a(0),  32'd0);
    chk("t5_d0",  mon_d(0),  32'h0302_0100);
    chk("t5_a15", mon_a(15), 32'd15);

    // 6: reset in the middle of a word
    mon_addr.delete(); mon_data.delete();
    start_load(8);
    send(8'h55); send(8'h66); send(8'h77);
    byte_valid_i = 1'b0;
    rst_n = 1'b0;
    step();
    chk("t6_we",    32'(rom_we_o),     32'd0);
    chk("t6_waddr", 32'(rom_waddr_o),  32'd0);
    chk("t6_wdata", rom_wdata_o,       32'd0);
    chk("t6_ready", 32'(byte_ready_o), 32'd0);
    chk("t6_busy",  32'(busy_o),       32'd0);
    chk("t6_done",  32'(done_o),       32'd0);
    chk("t6_err",   32'(err_o),        32'd0);
    chk("t6_core",  32'(core_rst_o),   32'd1);
    step();
    rst_n = 1'b1;
    // Bytes offered in IDLE are ignored.
    send(8'h88); send(8'h99); send(8'hAA); send(8'hBB);
    byte_valid_i = 1'b0;
    step();
    chk("t6_idle_busy", 32'(busy_o), 32'd0);
    chk("t6_idle_done", 32'(done_o), 32'd0);
    chk("t6_nwr",       32'(mon_data.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
